// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Definitions shared between the VGA display path and its image loader:
//   - frame RAM address / data widths (display-side rom_addr / rom_data)
//   - default start-of-image marker byte
//   - loader state encoding
//   - width helper for counters that must hold a value up to a given maximum
// -----------------------------------------------------------------------------
package vga_pkg;

   localparam int unsigned VGA_ADDR_W   = 11;
   localparam int unsigned VGA_DATA_W   = 8;
   localparam logic [7:0]  VGA_HDR_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CHK  = 2'd2,
      ST_FIN  = 2'd3
   } loader_state_e;

   // Bits needed to represent every value in 0..max_val (at least 1).
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/vga_loader_timeout.sv
// -----------------------------------------------------------------------------
// vga_loader_timeout
// Idle-cycle counter for the image loader. Counts cycles while enabled and
// no byte is accepted; expire_o flags the cycle whose end would bring the
// count to TIMEOUT_CYC. A clear in the same cycle overrides expiry, so a
// byte arriving on the last allowed cycle wins.
// Ports:
//   clk_i     clock
//   rst_i     asynchronous active-high reset
//   en_i      count enable (loader is waiting for payload/check bytes)
//   clr_i     clear (byte accepted)
//   expire_o  timeout reached this cycle
// -----------------------------------------------------------------------------
module vga_loader_timeout
   import vga_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 1000000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   input  logic clr_i,
   output logic expire_o
);

   localparam int unsigned     CNT_W = cnt_width(TIMEOUT_CYC);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != LAST + 1'b1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/vga_image_loader.sv
// -----------------------------------------------------------------------------
// vga_image_loader
// Write side of the VGA frame RAM. Takes a valid/ready byte stream, waits for
// the HDR_BYTE marker, then writes DEPTH payload bytes to consecutive RAM
// addresses (one cycle after each transfer) and marks the image valid.
// An idle gap of TIMEOUT_CYC cycles during a load aborts it with load_err.
//
// Optional build macro VGA_IMAGE_LOADER_CHECKSUM_EN: one extra byte after the
// payload must equal the XOR of all payload bytes, otherwise the load fails.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_data/in_valid     stream byte and its valid
//   in_ready             loader can accept a byte
//   ram_wr_en/addr/data  frame RAM write port
//   load_busy            loader not idle
//   load_done            one-cycle pulse on a successful load
//   load_err             sticky error, cleared by the next header
//   img_valid            RAM holds a complete, good image
// -----------------------------------------------------------------------------
module vga_image_loader
   import vga_pkg::*;
#(
   parameter int unsigned        ADDR_W      = VGA_ADDR_W,
   parameter int unsigned        DATA_W      = VGA_DATA_W,
   parameter int unsigned        DEPTH       = 2048,
   parameter logic [DATA_W-1:0]  HDR_BYTE    = VGA_HDR_BYTE,
   parameter int unsigned        TIMEOUT_CYC = 1000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              ram_wr_en,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_err,
   output logic              img_valid
);

   // Terminal index compared against the count, so DEPTH = 2^ADDR_W never
   // relies on counter overflow.
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   loader_state_e     state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic              in_ready_q;
   logic              wr_en_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              done_q;
   logic              err_q;
   logic              valid_q;
`ifdef VGA_IMAGE_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] xor_q;
`endif

   logic xfer;
   logic tmo_en;
   logic tmo_exp;

   assign xfer   = in_valid && in_ready_q;
   assign tmo_en = (state_q == ST_LOAD) || (state_q == ST_CHK);

   // Entry to LOAD is always a byte transfer, so clearing on every transfer
   // also covers the clear-on-entry case.
   vga_loader_timeout #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk_i    (clk),
      .rst_i    (rst),
      .en_i     (tmo_en),
      .clr_i    (xfer),
      .expire_o (tmo_exp)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         in_ready_q <= 1'b0;
         wr_en_q    <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
`ifdef VGA_IMAGE_LOADER_CHECKSUM_EN
         xor_q      <= '0;
`endif
      end else begin
         wr_en_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               in_ready_q <= 1'b1;
               if (xfer && (in_data == HDR_BYTE)) begin
                  state_q <= ST_LOAD;
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
                  valid_q <= 1'b0;
`ifdef VGA_IMAGE_LOADER_CHECKSUM_EN
                  xor_q   <= '0;
`endif
               end
            end

            ST_LOAD: begin
               if (xfer) begin
                  wr_en_q <= 1'b1;
                  addr_q  <= cnt_q;
                  data_q  <= in_data;
`ifdef VGA_IMAGE_LOADER_CHECKSUM_EN
                  xor_q   <= xor_q ^ in_data;
`endif
                  if (cnt_q == LAST_IDX) begin
`ifdef VGA_IMAGE_LOADER_CHECKSUM_EN
                     state_q    <= ST_CHK;
`else
                     state_q    <= ST_FIN;
                     in_ready_q <= 1'b0;
                     done_q     <= 1'b1;
                     valid_q    <= 1'b1;
`endif
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end else if (tmo_exp) begin
                  state_q <= ST_IDLE;
                  err_q   <= 1'b1;
               end
            end

            ST_CHK: begin
`ifdef VGA_IMAGE_LOADER_CHECKSUM_EN
               if (xfer) begin
                  if (in_data == xor_q) begin
                     state_q    <= ST_FIN;
                     in_ready_q <= 1'b0;
                     done_q     <= 1'b1;
                     valid_q    <= 1'b1;
                  end else begin
                     state_q <= ST_IDLE;
                     err_q   <= 1'b1;
                  end
               end else if (tmo_exp) begin
                  state_q <= ST_IDLE;
                  err_q   <= 1'b1;
               end
`else
               state_q <= ST_IDLE;
`endif
            end

            ST_FIN: begin
               state_q    <= ST_IDLE;
               in_ready_q <= 1'b1;
            end

            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign ram_wr_en = wr_en_q;
   assign ram_addr  = addr_q;
   assign ram_data  = data_q;
   assign load_busy = (state_q != ST_IDLE);
   assign load_done = done_q;
   assign load_err  = err_q;
   assign img_valid = valid_q;

endmodule
